// File: rtl/bullet_fire_ctrl_if.sv
// Handshake bundle between the game-state logic (master) and the fire scheduler (slave).
`timescale 1ns/1ps
interface bullet_fire_ctrl_if #(
  parameter int unsigned BULLET_NUM = 8,
  parameter int unsigned IDX_W      = 3
);
  logic                  run_i;
  logic [BULLET_NUM-1:0] slot_busy_i;
  logic                  powerup_i;
  logic                  shoot_o;
  logic [IDX_W-1:0]      shoot_idx_o;
  logic                  mode_o;
  logic                  pending_o;
  logic [3:0]            double_left_o;

  modport master (
    output run_i, slot_busy_i, powerup_i,
    input  shoot_o, shoot_idx_o, mode_o, pending_o, double_left_o
  );

  modport slave (
    input  run_i, slot_busy_i, powerup_i,
    output shoot_o, shoot_idx_o, mode_o, pending_o, double_left_o
  );
endinterface

// File: rtl/bullet_fire_ctrl.sv
// Player fire scheduler: shot cadence, circular free-slot allocation and timed double-shot mode.
`timescale 1ns/1ps
module bullet_fire_ctrl #(
  parameter int unsigned BULLET_NUM    = 8,
  parameter int unsigned IDX_W         = 3,
  parameter int unsigned CNT_MAX_SHOOT = 50_000_000,
  parameter int unsigned CNT_W         = 26,
  parameter int unsigned DOUBLE_TICKS  = 8,
  parameter int unsigned TICK_CYCLES   = 250_000_000,
  parameter int unsigned TICK_W        = 28
) (
  input logic                clk_run,
  input logic                rst_n,
  bullet_fire_ctrl_if.slave  bus_io
);

  localparam logic [CNT_W-1:0]  CntLast  = CNT_W'(CNT_MAX_SHOOT - 1);
  localparam logic [TICK_W-1:0] TickLast = TICK_W'(TICK_CYCLES - 1);
  localparam logic [3:0]        DlLoad   = (DOUBLE_TICKS > 15) ? 4'd15 : 4'(DOUBLE_TICKS);
  localparam logic [IDX_W-1:0]  IdxLast  = IDX_W'(BULLET_NUM - 1);

  typedef enum logic [1:0] {StIdle, StRun, StWait, StPause} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TICK_W-1:0]     presc_q, presc_d;
  logic [3:0]            dl_q, dl_d;
  logic                  mode_q, mode_d;
  logic                  shot_mode_q, shot_mode_d;
  logic                  shoot_q, shoot_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [1:0]            blk_q, blk_d;

  logic                  active, fire_due, tick_wrap, pu_take, fire, found;
  logic [IDX_W-1:0]      sel_idx;
  logic [BULLET_NUM-1:0] blk_mask, avail;

  assign active    = (state_q != StIdle) && bus_io.run_i;
  assign fire_due  = active && (cnt_q == CntLast);
  assign tick_wrap = active && (presc_q == TickLast);
  assign pu_take   = bus_io.powerup_i && bus_io.run_i &&
                     ((state_q == StRun) || (state_q == StWait));

  // The slot just loaded stays reserved while the datapath latches it.
  always_comb begin
    blk_mask = '0;
    if (blk_q != 2'd0) blk_mask[last_q] = 1'b1;
  end

  assign avail = ~bus_io.slot_busy_i & ~blk_mask;

  // Circular search starting after the last slot used; descending loop so the nearest wins.
  always_comb begin
    int unsigned pos;
    found   = 1'b0;
    sel_idx = '0;
    pos     = 0;
    for (int k = int'(BULLET_NUM) - 1; k >= 0; k--) begin
      pos = int'(last_q) + 1 + k;
      if (pos >= BULLET_NUM) pos = pos - BULLET_NUM;
      if (avail[pos]) begin
        found   = 1'b1;
        sel_idx = IDX_W'(pos);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.run_i) state_d = StRun;
      end
      StRun, StWait, StPause: begin
        if (!bus_io.run_i) begin
          state_d = StPause;
        end else if (fire_due || (state_q == StWait)) begin
          if (found) begin
            fire    = 1'b1;
            state_d = StRun;
          end else begin
            state_d = StWait;
          end
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    presc_d     = presc_q;
    dl_d        = dl_q;
    mode_d      = mode_q;
    shoot_d     = fire;
    idx_d       = idx_q;
    last_d      = last_q;
    shot_mode_d = shot_mode_q;
    blk_d       = (blk_q != 2'd0) ? blk_q - 2'd1 : 2'd0;

    if (state_q == StIdle) begin
      cnt_d   = '0;
      presc_d = '0;
      dl_d    = 4'd0;
      mode_d  = 1'b0;
    end else begin
      if (active) cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
      if (pu_take) begin
        presc_d = '0;
        dl_d    = DlLoad;
        mode_d  = 1'b1;
      end else if (active) begin
        presc_d = (presc_q == TickLast) ? '0 : presc_q + 1'b1;
        if (tick_wrap && (dl_q != 4'd0)) begin
          dl_d = dl_q - 4'd1;
          if (dl_q == 4'd1) mode_d = 1'b0;
        end
      end
    end

    // The shot keeps the mode that was in force before any same-edge power-up change.
    if (fire) begin
      idx_d       = sel_idx;
      last_d      = sel_idx;
      shot_mode_d = mode_q;
      blk_d       = 2'd3;
    end
  end

  always_ff @(posedge clk_run or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      presc_q     <= '0;
      dl_q        <= 4'd0;
      mode_q      <= 1'b0;
      shot_mode_q <= 1'b0;
      shoot_q     <= 1'b0;
      idx_q       <= '0;
      last_q      <= IdxLast;
      blk_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      presc_q     <= presc_d;
      dl_q        <= dl_d;
      mode_q      <= mode_d;
      shot_mode_q <= shot_mode_d;
      shoot_q     <= shoot_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      blk_q       <= blk_d;
    end
  end

  assign bus_io.shoot_o       = shoot_q;
  assign bus_io.shoot_idx_o   = idx_q;
  assign bus_io.mode_o        = shoot_q ? shot_mode_q : mode_q;
  assign bus_io.pending_o     = (state_q == StWait);
  assign bus_io.double_left_o = dl_q;

endmodule

// File: doc/bullet_fire_ctrl.md
Name: bullet_fire_ctrl

Overview:
Fire scheduler for the player bullet pool. Generates the periodic shoot strobe and allocates a free bullet slot, replacing blind round-robin reuse. Manages the single/double shot mode with a timed power-up. Sits between the game-state logic and the bullet datapath in the clk_run domain.

Parameters:
BULLET_NUM, 8, number of bullet slots (2..16)
IDX_W, 3, slot index width, ceil(log2(BULLET_NUM))
CNT_MAX_SHOOT, 50_000_000, clk_run cycles between shots
CNT_W, 26, cadence counter width
DOUBLE_TICKS, 8, power-up duration in ticks
TICK_CYCLES, 250_000_000, clk_run cycles per tick
TICK_W, 28, tick prescaler width

Ports:
clk_run  in  1  run clock
rst_n  in  1  asynchronous active-low reset
run_i  in  1  game running level; 0 means paused or game over
slot_busy_i  in  BULLET_NUM  per-slot occupied flags from the bullet datapath (any visible part)
powerup_i  in  1  single-cycle pulse: double-shot power-up collected
shoot_o  out  1  single-cycle pulse: load slot shoot_idx_o at the player position
shoot_idx_o  out  IDX_W  slot to load; valid when shoot_o=1
mode_o  out  1  0 = single, 1 = double; sampled by the datapath on shoot_o
pending_o  out  1  shot due but no slot free
double_left_o  out  4  remaining power-up ticks (saturates at 15)

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE, cadence counter=0, shoot_o=0, shoot_idx_o=0, mode_o=0, pending_o=0, double_left_o=0, prescaler=0.
- Main FSM:
  - IDLE: counters held at 0. run_i=1 -> RUN next cycle.
  - RUN: cadence counter increments each cycle. At CNT_MAX_SHOOT-1 it wraps to 0 and raises internal fire_due. run_i=0 -> PAUSE.
  - WAIT: entered when fire_due finds no free slot; pending_o=1. The counter keeps running. A slot frees -> fire that cycle and return to RUN. run_i=0 -> PAUSE, and the pending shot is dropped.
  - PAUSE: cadence counter, prescaler and double_left_o are frozen; pending_o=0. run_i=1 -> RUN with the counter resumed (not cleared).
- Allocation: free = ~slot_busy_i. The chosen slot is the lowest index i >= (last_idx+1) mod BULLET_NUM, searched circularly. last_idx resets to BULLET_NUM-1, so the first shot uses slot 0.
- Fire output: registered. shoot_o=1 and shoot_idx_o are asserted the cycle after fire_due or after a free slot appears in WAIT. shoot_o is 1 for exactly one cycle. mode_o is stable during that cycle.
- Blackout: the just-shot slot is treated as busy for 2 cycles after shoot_o, to cover datapath latency.
- fire_due arriving while in WAIT: it merges with the pending shot; at most one shot is pending at a time.
- Power-up:
  - powerup_i in RUN or WAIT: double_left_o loads DOUBLE_TICKS, the prescaler clears, and mode_o=1 from the next cycle.
  - Retrigger reloads to the full DOUBLE_TICKS; there is no accumulation.
  - Each prescaler wrap (TICK_CYCLES-1 -> 0) decrements double_left_o while it is nonzero.
  - When double_left_o reaches 0, mode_o=0 on the same edge.
  - powerup_i in IDLE or PAUSE is ignored.
- Simultaneous powerup_i and a fire cycle: the shot uses the mode_o value before the update.
- rst_n asserted mid-shot clears shoot_o immediately (asynchronous reset).

Test Plan:
- Reset, then run_i=1, CNT_MAX_SHOOT=4, slot_busy_i=0 -> shoot_o pulses every 4 cycles with shoot_idx_o 0,1,2,...,7,0. mode_o=0 throughout.
- slot_busy_i=8'b1111_1110 with last_idx=0 -> next shot goes to slot 0 only after the circular search finds 1..7 busy. With all 8'hFF: pending_o=1, no shoot_o. Clearing bit 5 -> shoot_o next cycle, idx=5, pending_o=0.
- DOUBLE_TICKS=3, TICK_CYCLES=10, powerup_i pulse -> mode_o=1 next cycle. double_left_o goes 3,2,1,0 at 10-cycle steps, and mode_o=0 exactly when it reaches 0. A retrigger at double_left_o=1 -> reload to 3.
- run_i=0 for 20 cycles with counter=2 and double_left_o=2 -> no shoot_o, values frozen. run_i=1 -> next shot after 2 more cycles.
- Pending in WAIT, then run_i=0 -> pending_o=0. On resume, no stale shot fires before the next cadence wrap.
- rst_n low during the shoot_o cycle -> shoot_o=0 asynchronously. After release, the first shot uses slot 0.
